// File: rtl/frame_egress_pkg.sv
// Shared types for the frame egress reader: controller states and skid-buffer entries.
// Widths here are the defaults the top-level parameters track.
package frame_egress_pkg;

    localparam int EG_ADDR_W = 11;
    localparam int EG_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REWIND,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } eg_state_e;

    typedef struct packed {
        logic                 last;
        logic [EG_DATA_W-1:0] dat;
    } skid_entry_t;

endpackage

// File: rtl/egress_skid.sv
// Two-entry FIFO absorbing the frame buffer's one-cycle read latency; head is registered.
// Flush empties it at the next edge; the caller guarantees no push when full.
module egress_skid
    import frame_egress_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_push,
    input  skid_entry_t i_push_ent,
    input  logic        i_pop,
    output skid_entry_t o_head,
    output logic [1:0]  o_occ
);

    skid_entry_t r_mem [2];
    logic        r_wr_idx;
    logic        r_rd_idx;
    logic [1:0]  r_occ;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_idx] <= i_push_ent;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (i_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head = r_mem[r_rd_idx];
    assign o_occ  = r_occ;

endmodule

// File: rtl/frame_egress.sv
// Rewinds the frame FIFO to a committed frame, reads it out and streams it as AXI-stream with tlast.
// First beat 4 cycles after tx_start; reads stall so that buffered plus in-flight words never exceed 2.
module frame_egress
    import frame_egress_pkg::*;
#(
    parameter int ADDR_WIDTH = EG_ADDR_W,
    parameter int DATA_WIDTH = EG_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tx_start,
    input  logic [ADDR_WIDTH:0]   i_tx_start_ptr,
    input  logic [ADDR_WIDTH:0]   i_tx_end_ptr,
    input  logic                  i_tx_abort,
    output logic                  o_tx_busy,
    output logic                  o_tx_done,
    output logic                  o_tx_aborted,
    output logic                  o_frame_ren,
    output logic                  o_frame_rrst,
    output logic [ADDR_WIDTH:0]   o_frame_rst_rptr,
    input  logic [ADDR_WIDTH:0]   i_frame_rptr,
    input  logic [DATA_WIDTH+3:0] i_frame_rdata,
    output logic [DATA_WIDTH-1:0] o_egress_tdata,
    output logic                  o_egress_tvalid,
    output logic                  o_egress_tlast,
    input  logic                  i_egress_tready
);

    localparam int PW = ADDR_WIDTH + 1;

    eg_state_e     r_state;
    eg_state_e     w_next;
    logic [PW-1:0] r_start_ptr;
    logic [PW-1:0] r_end_ptr;
    logic [PW-1:0] r_len;
    logic [PW-1:0] r_issued;
    logic [PW-1:0] r_rcvd;
    logic          r_inflight;
    logic          r_aborted;

    logic          w_pop;
    logic          w_push;
    logic          w_abort;
    logic          w_ren;
    logic          w_rrst;
    logic          w_done;
    logic [PW-1:0] w_rst_rptr;
    logic [2:0]    w_fill;
    logic [1:0]    w_occ;
    skid_entry_t   w_head;
    skid_entry_t   w_push_ent;
    logic          w_unused_bits;

    // Read pointer is observed only for debug; rdata's top nibble is reserved.
    assign w_unused_bits = ^{i_frame_rdata[DATA_WIDTH+3:DATA_WIDTH], i_frame_rptr};

    assign o_egress_tvalid = (w_occ != 2'd0);
    assign w_pop           = o_egress_tvalid & i_egress_tready;
    assign w_abort         = i_tx_abort & (r_state inside {ST_REWIND, ST_STREAM, ST_DRAIN});
    assign w_push          = r_inflight & ~w_abort;
    // Words buffered after this edge if nothing new is read.
    assign w_fill          = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_push_ent      = '{last: (r_rcvd == r_len - PW'(1)),
                               dat:  i_frame_rdata[DATA_WIDTH-1:0]};

    always_comb begin
        w_next     = r_state;
        w_ren      = 1'b0;
        w_rrst     = 1'b0;
        w_rst_rptr = '0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_start) w_next = ST_REWIND;
            end
            ST_REWIND: begin
                w_rrst     = 1'b1;
                w_rst_rptr = r_start_ptr;
                w_next     = (r_len == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                if (r_issued == r_len) w_next = ST_DRAIN;
                else if (w_fill < 3'd2) w_ren = 1'b1;
            end
            ST_DRAIN: begin
                if (w_fill == 3'd0) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // Abort parks the FIFO read pointer past the frame so the buffer space is released.
        if (w_abort) begin
            w_ren      = 1'b0;
            w_rrst     = 1'b1;
            w_rst_rptr = r_end_ptr;
            w_next     = ST_DONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_start_ptr <= '0;
            r_end_ptr   <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_rcvd      <= '0;
            r_inflight  <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_ren;
            if (r_state == ST_IDLE && i_tx_start) begin
                r_start_ptr <= i_tx_start_ptr;
                r_end_ptr   <= i_tx_end_ptr;
                r_len       <= i_tx_end_ptr - i_tx_start_ptr;
                r_issued    <= '0;
                r_rcvd      <= '0;
                r_aborted   <= 1'b0;
            end
            if (w_ren)   r_issued  <= r_issued + PW'(1);
            if (w_push)  r_rcvd    <= r_rcvd + PW'(1);
            if (w_abort) r_aborted <= 1'b1;
        end
    end

    egress_skid u_skid (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (w_abort),
        .i_push     (w_push),
        .i_push_ent (w_push_ent),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_occ      (w_occ)
    );

    assign o_tx_busy        = (r_state != ST_IDLE);
    assign o_tx_done        = w_done;
    assign o_tx_aborted     = w_done & r_aborted;
    assign o_frame_ren      = w_ren;
    assign o_frame_rrst     = w_rrst;
    assign o_frame_rst_rptr = w_rst_rptr;
    assign o_egress_tdata   = o_egress_tvalid ? w_head.dat : '0;
    assign o_egress_tlast   = o_egress_tvalid & w_head.last;

endmodule
